eth_ber_stats_accum: RTL and testbench
======================================

ETH_BER_STATS_ACCUM -- requirements
Module: eth_ber_stats_accum

Interface
REQ-001 SHALL have parameter MAX_WORD_BITS, default 64, meaning the maximum bit count credited per input word.
REQ-002 SHALL have port hb0_gtwiz_userclk_tx_usrclk2_int, input, 1 bit: the single clock; all logic sits on its rising edge.
REQ-003 SHALL have port hb0_gtwiz_reset_all_n_int, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port chk_valid, input, 1 bit: the checker word-result is valid this cycle.
REQ-005 SHALL have port chk_sof, input, 1 bit: the word is the first of a frame; qualified by chk_valid.
REQ-006 SHALL have port chk_eof, input, 1 bit: the word is the last of a frame; qualified by chk_valid.
REQ-007 SHALL have port chk_err_cnt, input, 7 bits: number of errored bits in the word.
REQ-008 SHALL have port chk_bit_cnt, input, 7 bits: number of bits compared in the word.
REQ-009 SHALL have port error_accumulator_clear, input, 1 bit: level-sensitive clear, from the same clock domain.
REQ-010 SHALL have port num_frames_recvd, output, 32 bits: count of completed frames.
REQ-011 SHALL have port num_errors_this_fr, output, 32 bits: errored bits in the last completed frame.
REQ-012 SHALL have port total_bits_this_fr, output, 32 bits: compared bits in the last completed frame.
REQ-013 SHALL have port accumulated_error, output, 64 bits: total errored bits since clear.
REQ-014 SHALL have port total_bits_accumulated, output, 64 bits: total compared bits since clear.
REQ-015 SHALL have port frames_aborted, output, 16 bits: count of frames restarted by an unexpected SOF.
REQ-016 SHALL have port stats_update, output, 1 bit: one-cycle pulse when the frame outputs have just updated.

Function
REQ-017 SHALL clamp each input word before use:
- bits = min(chk_bit_cnt, MAX_WORD_BITS).
- errs = min(chk_err_cnt, bits).
REQ-018 SHALL run an FSM with two states, IDLE and IN_FRAME, and SHALL keep 32-bit running sums fr_err and fr_bits.
REQ-019 In IDLE, a valid word with chk_sof=0 SHALL be ignored, with no counter changes.
REQ-020 In IDLE, a valid word with chk_sof=1 and chk_eof=0 SHALL:
- load fr_err=errs and fr_bits=bits;
- move the FSM to IN_FRAME.
REQ-021 In IN_FRAME, a valid word with chk_sof=0 and chk_eof=0 SHALL add errs and bits to the running sums.
REQ-022 In IN_FRAME, a valid word with chk_sof=1 SHALL:
- increment frames_aborted (saturating at 0xFFFF);
- discard the old sums and reload them from the current word;
- stay in IN_FRAME, unless chk_eof=1, which REQ-023 then governs.
REQ-023 A valid word with chk_eof=1, in IN_FRAME or together with chk_sof=1 in any state (single-word frame), SHALL complete the frame. One cycle after that word:
- num_errors_this_fr and total_bits_this_fr equal the frame sums including that word;
- num_frames_recvd has been incremented;
- accumulated_error and total_bits_accumulated have each had the frame sum added;
- stats_update=1 for exactly that one cycle;
- the FSM is in IDLE.
REQ-024 chk_eof=1 with chk_sof=0 while in IDLE SHALL be ignored.
REQ-025 Arithmetic SHALL saturate, never wrap:
- 32-bit sums and counters saturate at 0xFFFFFFFF;
- 64-bit accumulators saturate at 0xFFFFFFFF_FFFFFFFF.
REQ-026 Words with chk_valid=0 SHALL change no state.
REQ-027 While error_accumulator_clear=1, at every clock edge:
- all outputs except stats_update are zeroed;
- running sums are zeroed;
- the FSM is forced to IDLE;
- stats_update=0;
- input words are ignored.
Clear has priority over any simultaneous SOF or EOF.
REQ-028 All outputs SHALL be registered; there SHALL be no combinational path from input to output.

Reset
REQ-029 Asserting reset low SHALL, immediately and asynchronously:
- zero all outputs, running sums and frames_aborted;
- set the FSM to IDLE.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame; after release, the first frame counted SHALL be one beginning with SOF.

Verification
REQ-031 The bench SHALL cover a 3-word frame with (err,bits) = (1,64),(0,64),(2,32): one cycle after EOF, the outputs are num_errors_this_fr=3, total_bits_this_fr=160, num_frames_recvd=1, accumulated_error=3, total_bits_accumulated=160, with a single stats_update pulse.
REQ-032 The bench SHALL cover an SOF,(5,64) word, then SOF,(1,64), then EOF,(0,64): frames_aborted=1, num_errors_this_fr=1, total_bits_this_fr=128, num_frames_recvd=1.
REQ-033 The bench SHALL cover a word with chk_bit_cnt=100 and chk_err_cnt=90 in a single-word SOF+EOF frame: total_bits_this_fr=64 and num_errors_this_fr=64.
REQ-034 The bench SHALL cover error_accumulator_clear asserted in the same cycle as an EOF word: all counters read 0 next cycle, stats_update stays 0, and the frame is not counted.
REQ-035 The bench SHALL cover accumulated_error preloaded (via forced state) to 0xFFFFFFFF_FFFFFFF0, followed by a frame with 32 errors: accumulated_error=0xFFFFFFFF_FFFFFFFF.
REQ-036 The bench SHALL cover reset asserted low between SOF and EOF, then released, then a stray EOF-only word: all outputs stay 0.

Source files
------------

// File: rtl/eth_ber_stats_accum.sv
// Per-frame and cumulative bit-error statistics from a PRBS checker word stream.
// Outputs update one cycle after the EOF word; no backpressure, every valid word is consumed.
module eth_ber_stats_accum #(
   parameter int MAX_WORD_BITS = 64
) (
   input  logic        hb0_gtwiz_userclk_tx_usrclk2_int,
   input  logic        hb0_gtwiz_reset_all_n_int,
   input  logic        chk_valid,
   input  logic        chk_sof,
   input  logic        chk_eof,
   input  logic [6:0]  chk_err_cnt,
   input  logic [6:0]  chk_bit_cnt,
   input  logic        error_accumulator_clear,
   output logic [31:0] num_frames_recvd,
   output logic [31:0] num_errors_this_fr,
   output logic [31:0] total_bits_this_fr,
   output logic [63:0] accumulated_error,
   output logic [63:0] total_bits_accumulated,
   output logic [15:0] frames_aborted,
   output logic        stats_update
);

   localparam logic [6:0] MAX_BITS = (MAX_WORD_BITS > 127) ? 7'd127 : 7'(MAX_WORD_BITS);

   typedef enum logic {IDLE, IN_FRAME} state_t;

   state_t      state_q, state_d;
   logic [31:0] sum_err_q, sum_err_d, sum_bits_q, sum_bits_d;
   logic [31:0] frames_q, frames_d, fr_err_q, fr_err_d, fr_bits_q, fr_bits_d;
   logic [63:0] acc_err_q, acc_err_d, acc_bits_q, acc_bits_d;
   logic [15:0] aborted_q, aborted_d;
   logic        upd_q, upd_d;

   logic [6:0]  bits_w, errs_w;
   logic [31:0] new_err_w, new_bits_w;
   logic        take_w;

   function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[32] ? 32'hFFFF_FFFF : s[31:0];
   endfunction

   function automatic logic [63:0] sat_add64(input logic [63:0] a, input logic [63:0] b);
      logic [64:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[64] ? 64'hFFFF_FFFF_FFFF_FFFF : s[63:0];
   endfunction

   // Errors can never exceed the bits they were counted over.
   always_comb begin
      bits_w = (chk_bit_cnt > MAX_BITS) ? MAX_BITS : chk_bit_cnt;
      errs_w = (chk_err_cnt > bits_w) ? bits_w : chk_err_cnt;
   end

   always_ff @(posedge hb0_gtwiz_userclk_tx_usrclk2_int or negedge hb0_gtwiz_reset_all_n_int) begin
      if (!hb0_gtwiz_reset_all_n_int) state_q <= IDLE;
      else                            state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (error_accumulator_clear) begin
         state_d = IDLE;
      end else if (chk_valid) begin
         case (state_q)
            IDLE:     if (chk_sof && !chk_eof) state_d = IN_FRAME;
            IN_FRAME: if (chk_eof)             state_d = IDLE;
            default:                           state_d = IDLE;
         endcase
      end
   end

   // A word belongs to a frame if it opens one or arrives while one is open.
   always_comb begin
      sum_err_d  = sum_err_q;
      sum_bits_d = sum_bits_q;
      frames_d   = frames_q;
      fr_err_d   = fr_err_q;
      fr_bits_d  = fr_bits_q;
      acc_err_d  = acc_err_q;
      acc_bits_d = acc_bits_q;
      aborted_d  = aborted_q;
      upd_d      = 1'b0;
      take_w     = chk_valid && (chk_sof || state_q == IN_FRAME);
      new_err_w  = chk_sof ? {25'd0, errs_w} : sat_add32(sum_err_q, {25'd0, errs_w});
      new_bits_w = chk_sof ? {25'd0, bits_w} : sat_add32(sum_bits_q, {25'd0, bits_w});
      if (error_accumulator_clear) begin
         sum_err_d  = '0;
         sum_bits_d = '0;
         frames_d   = '0;
         fr_err_d   = '0;
         fr_bits_d  = '0;
         acc_err_d  = '0;
         acc_bits_d = '0;
         aborted_d  = '0;
      end else if (take_w) begin
         if (chk_sof && state_q == IN_FRAME && aborted_q != 16'hFFFF)
            aborted_d = aborted_q + 16'd1;
         if (chk_eof) begin
            sum_err_d  = '0;
            sum_bits_d = '0;
            fr_err_d   = new_err_w;
            fr_bits_d  = new_bits_w;
            frames_d   = sat_add32(frames_q, 32'd1);
            acc_err_d  = sat_add64(acc_err_q, {32'd0, new_err_w});
            acc_bits_d = sat_add64(acc_bits_q, {32'd0, new_bits_w});
            upd_d      = 1'b1;
         end else begin
            sum_err_d  = new_err_w;
            sum_bits_d = new_bits_w;
         end
      end
   end

   always_ff @(posedge hb0_gtwiz_userclk_tx_usrclk2_int or negedge hb0_gtwiz_reset_all_n_int) begin
      if (!hb0_gtwiz_reset_all_n_int) begin
         sum_err_q  <= '0;
         sum_bits_q <= '0;
         frames_q   <= '0;
         fr_err_q   <= '0;
         fr_bits_q  <= '0;
         acc_err_q  <= '0;
         acc_bits_q <= '0;
         aborted_q  <= '0;
         upd_q      <= 1'b0;
      end else begin
         sum_err_q  <= sum_err_d;
         sum_bits_q <= sum_bits_d;
         frames_q   <= frames_d;
         fr_err_q   <= fr_err_d;
         fr_bits_q  <= fr_bits_d;
         acc_err_q  <= acc_err_d;
         acc_bits_q <= acc_bits_d;
         aborted_q  <= aborted_d;
         upd_q      <= upd_d;
      end
   end

   assign num_frames_recvd       = frames_q;
   assign num_errors_this_fr     = fr_err_q;
   assign total_bits_this_fr     = fr_bits_q;
   assign accumulated_error      = acc_err_q;
   assign total_bits_accumulated = acc_bits_q;
   assign frames_aborted         = aborted_q;
   assign stats_update           = upd_q;

endmodule

// File: tb/tb_eth_ber_stats_accum.sv
// Directed bench for eth_ber_stats_accum; expected values are hand-computed per scenario.
module tb_eth_ber_stats_accum;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        chk_valid = 1'b0, chk_sof = 1'b0, chk_eof = 1'b0, clr = 1'b0;
   logic [6:0]  chk_err_cnt = '0, chk_bit_cnt = '0;
   logic [31:0] num_frames_recvd, num_errors_this_fr, total_bits_this_fr;
   logic [63:0] accumulated_error, total_bits_accumulated;
   logic [15:0] frames_aborted;
   logic        stats_update;
   int          n_cmp = 0, n_bad = 0;

   always #5 clk = ~clk;

   eth_ber_stats_accum #(.MAX_WORD_BITS(64)) dut (
      .hb0_gtwiz_userclk_tx_usrclk2_int(clk),
      .hb0_gtwiz_reset_all_n_int(rst_n),
      .chk_valid(chk_valid),
      .chk_sof(chk_sof),
      .chk_eof(chk_eof),
      .chk_err_cnt(chk_err_cnt),
      .chk_bit_cnt(chk_bit_cnt),
      .error_accumulator_clear(clr),
      .num_frames_recvd(num_frames_recvd),
      .num_errors_this_fr(num_errors_this_fr),
      .total_bits_this_fr(total_bits_this_fr),
      .accumulated_error(accumulated_error),
      .total_bits_accumulated(total_bits_accumulated),
      .frames_aborted(frames_aborted),
      .stats_update(stats_update)
   );

   // Drive one cycle of inputs, then sample 1 time unit after the capturing edge.
   task automatic send(input logic vld, input logic sof, input logic eof,
                       input logic [6:0] err, input logic [6:0] bits, input logic c);
      @(negedge clk);
      chk_valid = vld; chk_sof = sof; chk_eof = eof;
      chk_err_cnt = err; chk_bit_cnt = bits; clr = c;
      @(posedge clk);
      #1;
      chk_valid = 1'b0; chk_sof = 1'b0; chk_eof = 1'b0; clr = 1'b0;
   endtask

   task automatic test_reset;
      #3 rst_n = 1'b0;
      #1;
      n_cmp++; if (num_frames_recvd !== 32'd0) begin n_bad++; $display("FAIL rst_frames: got %0d want 0", num_frames_recvd); end
      n_cmp++; if (num_errors_this_fr !== 32'd0) begin n_bad++; $display("FAIL rst_fr_err: got %0d want 0", num_errors_this_fr); end
      n_cmp++; if (total_bits_this_fr !== 32'd0) begin n_bad++; $display("FAIL rst_fr_bits: got %0d want 0", total_bits_this_fr); end
      n_cmp++; if (accumulated_error !== 64'd0) begin n_bad++; $display("FAIL rst_acc_err: got %0h want 0", accumulated_error); end
      n_cmp++; if (total_bits_accumulated !== 64'd0) begin n_bad++; $display("FAIL rst_acc_bits: got %0h want 0", total_bits_accumulated); end
      n_cmp++; if (frames_aborted !== 16'd0) begin n_bad++; $display("FAIL rst_aborted: got %0d want 0", frames_aborted); end
      n_cmp++; if (stats_update !== 1'b0) begin n_bad++; $display("FAIL rst_upd: got %0b want 0", stats_update); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_three_word;
      send(1, 1, 0, 7'd1, 7'd64, 0);
      n_cmp++; if (stats_update !== 1'b0) begin n_bad++; $display("FAIL tw_upd_early: got %0b want 0", stats_update); end
      send(1, 0, 0, 7'd0, 7'd64, 0);
      send(1, 0, 1, 7'd2, 7'd32, 0);
      n_cmp++; if (num_errors_this_fr !== 32'd3) begin n_bad++; $display("FAIL tw_fr_err: got %0d want 3", num_errors_this_fr); end
      n_cmp++; if (total_bits_this_fr !== 32'd160) begin n_bad++; $display("FAIL tw_fr_bits: got %0d want 160", total_bits_this_fr); end
      n_cmp++; if (num_frames_recvd !== 32'd1) begin n_bad++; $display("FAIL tw_frames: got %0d want 1", num_frames_recvd); end
      n_cmp++; if (accumulated_error !== 64'd3) begin n_bad++; $display("FAIL tw_acc_err: got %0d want 3", accumulated_error); end
      n_cmp++; if (total_bits_accumulated !== 64'd160) begin n_bad++; $display("FAIL tw_acc_bits: got %0d want 160", total_bits_accumulated); end
      n_cmp++; if (stats_update !== 1'b1) begin n_bad++; $display("FAIL tw_upd: got %0b want 1", stats_update); end
      send(0, 0, 0, 7'd0, 7'd0, 0);
      n_cmp++; if (stats_update !== 1'b0) begin n_bad++; $display("FAIL tw_upd_pulse: got %0b want 0", stats_update); end
   endtask

   task automatic test_idle_ignore;
      send(1, 0, 0, 7'd4, 7'd64, 0);
      send(1, 0, 1, 7'd4, 7'd64, 0);
      n_cmp++; if (num_frames_recvd !== 32'd1) begin n_bad++; $display("FAIL idle_frames: got %0d want 1", num_frames_recvd); end
      n_cmp++; if (accumulated_error !== 64'd3) begin n_bad++; $display("FAIL idle_acc_err: got %0d want 3", accumulated_error); end
      n_cmp++; if (stats_update !== 1'b0) begin n_bad++; $display("FAIL idle_upd: got %0b want 0", stats_update); end
   endtask

   task automatic test_abort;
      send(1, 1, 0, 7'd5, 7'd64, 0);
      send(1, 1, 0, 7'd1, 7'd64, 0);
      n_cmp++; if (frames_aborted !== 16'd1) begin n_bad++; $display("FAIL ab_aborted_mid: got %0d want 1", frames_aborted); end
      send(1, 0, 1, 7'd0, 7'd64, 0);
      n_cmp++; if (frames_aborted !== 16'd1) begin n_bad++; $display("FAIL ab_aborted: got %0d want 1", frames_aborted); end
      n_cmp++; if (num_errors_this_fr !== 32'd1) begin n_bad++; $display("FAIL ab_fr_err: got %0d want 1", num_errors_this_fr); end
      n_cmp++; if (total_bits_this_fr !== 32'd128) begin n_bad++; $display("FAIL ab_fr_bits: got %0d want 128", total_bits_this_fr); end
      n_cmp++; if (num_frames_recvd !== 32'd2) begin n_bad++; $display("FAIL ab_frames: got %0d want 2", num_frames_recvd); end
      n_cmp++; if (total_bits_accumulated !== 64'd288) begin n_bad++; $display("FAIL ab_acc_bits: got %0d want 288", total_bits_accumulated); end
   endtask

   task automatic test_clamp;
      send(1, 1, 1, 7'd90, 7'd100, 0);
      n_cmp++; if (total_bits_this_fr !== 32'd64) begin n_bad++; $display("FAIL cl_fr_bits: got %0d want 64", total_bits_this_fr); end
      n_cmp++; if (num_errors_this_fr !== 32'd64) begin n_bad++; $display("FAIL cl_fr_err: got %0d want 64", num_errors_this_fr); end
      n_cmp++; if (stats_update !== 1'b1) begin n_bad++; $display("FAIL cl_upd: got %0b want 1", stats_update); end
      send(1, 1, 1, 7'd20, 7'd10, 0);
      n_cmp++; if (num_errors_this_fr !== 32'd10) begin n_bad++; $display("FAIL cl_err_gt_bits: got %0d want 10", num_errors_this_fr); end
      n_cmp++; if (num_frames_recvd !== 32'd4) begin n_bad++; $display("FAIL cl_frames: got %0d want 4", num_frames_recvd); end
      n_cmp++; if (accumulated_error !== 64'd78) begin n_bad++; $display("FAIL cl_acc_err: got %0d want 78", accumulated_error); end
      n_cmp++; if (total_bits_accumulated !== 64'd362) begin n_bad++; $display("FAIL cl_acc_bits: got %0d want 362", total_bits_accumulated); end
   endtask

   task automatic test_invalid;
      send(0, 1, 1, 7'd5, 7'd5, 0);
      n_cmp++; if (num_frames_recvd !== 32'd4) begin n_bad++; $display("FAIL inv_frames: got %0d want 4", num_frames_recvd); end
      n_cmp++; if (stats_update !== 1'b0) begin n_bad++; $display("FAIL inv_upd: got %0b want 0", stats_update); end
      send(0, 1, 0, 7'd5, 7'd5, 0);
      send(1, 0, 1, 7'd5, 7'd5, 0);
      n_cmp++; if (num_frames_recvd !== 32'd4) begin n_bad++; $display("FAIL inv_no_start: got %0d want 4", num_frames_recvd); end
   endtask

   task automatic test_clear_eof;
      send(1, 1, 0, 7'd1, 7'd8, 0);
      send(1, 0, 1, 7'd3, 7'd8, 1);
      n_cmp++; if (num_frames_recvd !== 32'd0) begin n_bad++; $display("FAIL clr_frames: got %0d want 0", num_frames_recvd); end
      n_cmp++; if (num_errors_this_fr !== 32'd0) begin n_bad++; $display("FAIL clr_fr_err: got %0d want 0", num_errors_this_fr); end
      n_cmp++; if (total_bits_this_fr !== 32'd0) begin n_bad++; $display("FAIL clr_fr_bits: got %0d want 0", total_bits_this_fr); end
      n_cmp++; if (accumulated_error !== 64'd0) begin n_bad++; $display("FAIL clr_acc_err: got %0d want 0", accumulated_error); end
      n_cmp++; if (total_bits_accumulated !== 64'd0) begin n_bad++; $display("FAIL clr_acc_bits: got %0d want 0", total_bits_accumulated); end
      n_cmp++; if (frames_aborted !== 16'd0) begin n_bad++; $display("FAIL clr_aborted: got %0d want 0", frames_aborted); end
      n_cmp++; if (stats_update !== 1'b0) begin n_bad++; $display("FAIL clr_upd: got %0b want 0", stats_update); end
      send(1, 0, 1, 7'd2, 7'd8, 0);
      n_cmp++; if (num_frames_recvd !== 32'd0) begin n_bad++; $display("FAIL clr_idle_after: got %0d want 0", num_frames_recvd); end
   endtask

   task automatic test_saturate;
      @(negedge clk);
      force dut.acc_err_q = 64'hFFFF_FFFF_FFFF_FFF0;
      @(negedge clk);
      release dut.acc_err_q;
      send(1, 1, 1, 7'd32, 7'd32, 0);
      n_cmp++; if (accumulated_error !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_bad++; $display("FAIL sat_acc_err: got %0h want ffffffffffffffff", accumulated_error); end
      n_cmp++; if (total_bits_accumulated !== 64'd32) begin n_bad++; $display("FAIL sat_acc_bits: got %0d want 32", total_bits_accumulated); end
      n_cmp++; if (num_frames_recvd !== 32'd1) begin n_bad++; $display("FAIL sat_frames: got %0d want 1", num_frames_recvd); end
   endtask

   task automatic test_reset_midframe;
      send(1, 1, 0, 7'd4, 7'd64, 0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_cmp++; if (accumulated_error !== 64'd0) begin n_bad++; $display("FAIL rm_async_acc: got %0h want 0", accumulated_error); end
      n_cmp++; if (num_frames_recvd !== 32'd0) begin n_bad++; $display("FAIL rm_async_frames: got %0d want 0", num_frames_recvd); end
      @(negedge clk);
      rst_n = 1'b1;
      send(1, 0, 1, 7'd7, 7'd64, 0);
      n_cmp++; if (num_frames_recvd !== 32'd0) begin n_bad++; $display("FAIL rm_frames: got %0d want 0", num_frames_recvd); end
      n_cmp++; if (num_errors_this_fr !== 32'd0) begin n_bad++; $display("FAIL rm_fr_err: got %0d want 0", num_errors_this_fr); end
      n_cmp++; if (total_bits_this_fr !== 32'd0) begin n_bad++; $display("FAIL rm_fr_bits: got %0d want 0", total_bits_this_fr); end
      n_cmp++; if (accumulated_error !== 64'd0) begin n_bad++; $display("FAIL rm_acc_err: got %0d want 0", accumulated_error); end
      n_cmp++; if (total_bits_accumulated !== 64'd0) begin n_bad++; $display("FAIL rm_acc_bits: got %0d want 0", total_bits_accumulated); end
      n_cmp++; if (stats_update !== 1'b0) begin n_bad++; $display("FAIL rm_upd: got %0b want 0", stats_update); end
      send(1, 1, 1, 7'd1, 7'd8, 0);
      n_cmp++; if (num_frames_recvd !== 32'd1) begin n_bad++; $display("FAIL rm_first_frame: got %0d want 1", num_frames_recvd); end
      n_cmp++; if (num_errors_this_fr !== 32'd1) begin n_bad++; $display("FAIL rm_first_err: got %0d want 1", num_errors_this_fr); end
   endtask

   initial begin
      test_reset();
      test_three_word();
      test_idle_ignore();
      test_abort();
      test_clamp();
      test_invalid();
      test_clear_eof();
      test_saturate();
      test_reset_midframe();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
